// File: rtl/alu_execute_stage_pkg.sv
// Shared constants for the ALU execute stage: ARM DP opcodes, NZCV bit positions, multiply FSM states.
package alu_execute_stage_pkg;

  localparam logic [3:0] OpAnd = 4'h0;
  localparam logic [3:0] OpEor = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpRsb = 4'h3;
  localparam logic [3:0] OpAdd = 4'h4;
  localparam logic [3:0] OpAdc = 4'h5;
  localparam logic [3:0] OpSbc = 4'h6;
  localparam logic [3:0] OpRsc = 4'h7;
  localparam logic [3:0] OpTst = 4'h8;
  localparam logic [3:0] OpTeq = 4'h9;
  localparam logic [3:0] OpCmp = 4'hA;
  localparam logic [3:0] OpCmn = 4'hB;
  localparam logic [3:0] OpOrr = 4'hC;
  localparam logic [3:0] OpMov = 4'hD;
  localparam logic [3:0] OpBic = 4'hE;
  localparam logic [3:0] OpMvn = 4'hF;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } mul_state_e;

  function automatic logic is_arith_op(input logic [3:0] op);
    return op inside {OpSub, OpRsb, OpAdd, OpAdc, OpSbc, OpRsc, OpCmp, OpCmn};
  endfunction

  // Compare/test ops always write flags and never write back.
  function automatic logic is_test_op(input logic [3:0] op);
    return op inside {OpTst, OpTeq, OpCmp, OpCmn};
  endfunction

endpackage

// File: rtl/alu_seq_multiplier.sv
// Iterative shift-add MUL/MLA engine; finishes as soon as the remaining multiplier bits are zero.
module alu_seq_multiplier
  import alu_execute_stage_pkg::*;
#(
  parameter int unsigned DataW = 32,
  parameter int unsigned RdW   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DataW-1:0] mcand_i,
  input  logic [DataW-1:0] mplier_i,
  input  logic [DataW-1:0] acc_i,
  input  logic             accumulate_i,
  input  logic [RdW-1:0]   rd_i,
  input  logic             set_flags_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DataW-1:0] product_o,
  output logic [RdW-1:0]   rd_o,
  output logic             set_flags_o
);

  mul_state_e       state_q;
  logic [DataW-1:0] acc_q, mcand_q, mplier_q;
  logic [DataW-1:0] acc_next, mplier_next;

  always_comb begin
    acc_next    = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_next = mplier_q >> 1;
  end

  assign busy_o    = (state_q == StMul);
  assign done_o    = (state_q == StMul) && (mplier_next == '0);
  assign product_o = acc_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      rd_o        <= '0;
      set_flags_o <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StMul;
            acc_q       <= accumulate_i ? acc_i : '0;
            mcand_q     <= mcand_i;
            mplier_q    <= mplier_i;
            rd_o        <= rd_i;
            set_flags_o <= set_flags_i;
          end
        end
        StMul: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_next;
          if (mplier_next == '0) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/register_with_reset.sv
// Plain D register with asynchronous active-high reset to zero.
module register_with_reset #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/alu_execute_stage.sv
// ALU execute stage: ARM DP ops with NZCV generation, plus an optional stalling MUL/MLA engine
// enabled by defining ALU_EXECUTE_STAGE_MUL_EN.
module alu_execute_stage
  import alu_execute_stage_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] operand_a_in,
  input  logic [DATA_W-1:0] shifted_operandB_in,
  input  logic [DATA_W-1:0] acc_operand_in,
  input  logic              instr_exec_in,
  input  logic              carry_frm_barrel_shifter_in,
  input  logic [3:0]        alu_opcode_in,
  input  logic              set_flags_in,
  input  logic              mul_in,
  input  logic              accumulate_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] result_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              wb_en_out,
  output logic [3:0]        flags_out,
  output logic              flags_wr_out,
  output logic              stall_out
);

  logic              stall, accept;
  logic              mul_done, mul_set_flags;
  logic [DATA_W-1:0] mul_product;
  logic [RD_W-1:0]   mul_rd;

  assign accept    = valid_in & ~stall;
  assign stall_out = stall;

`ifdef ALU_EXECUTE_STAGE_MUL_EN
  alu_seq_multiplier #(
    .DataW(DATA_W),
    .RdW  (RD_W)
  ) u_mul (
    .clk_i       (clk_in),
    .rst_i       (reset_in),
    .start_i     (accept & instr_exec_in & mul_in),
    .mcand_i     (operand_a_in),
    .mplier_i    (shifted_operandB_in),
    .acc_i       (acc_operand_in),
    .accumulate_i(accumulate_in),
    .rd_i        (rd_in),
    .set_flags_i (set_flags_in),
    .busy_o      (stall),
    .done_o      (mul_done),
    .product_o   (mul_product),
    .rd_o        (mul_rd),
    .set_flags_o (mul_set_flags)
  );
`else
  logic unused_mul_inputs;
  assign unused_mul_inputs = ^{acc_operand_in, accumulate_in};
  assign stall         = 1'b0;
  assign mul_done      = 1'b0;
  assign mul_set_flags = 1'b0;
  assign mul_product   = '0;
  assign mul_rd        = '0;
`endif

  logic [DATA_W-1:0] add_x, add_y, dp_result;
  logic [DATA_W:0]   add_sum;
  logic              add_cin, is_arith, is_test;
  logic [3:0]        dp_flags, mul_flags;

  assign is_arith = is_arith_op(alu_opcode_in);
  assign is_test  = is_test_op(alu_opcode_in);

  // Subtracts are folded into one 33-bit adder as x + ~y + cin, so carry-out is NOT borrow.
  always_comb begin
    add_x   = operand_a_in;
    add_y   = shifted_operandB_in;
    add_cin = 1'b0;
    case (alu_opcode_in)
      OpSub, OpCmp: begin
        add_y   = ~shifted_operandB_in;
        add_cin = 1'b1;
      end
      OpRsb: begin
        add_x   = shifted_operandB_in;
        add_y   = ~operand_a_in;
        add_cin = 1'b1;
      end
      OpAdc: add_cin = flags_in[FlagC];
      OpSbc: begin
        add_y   = ~shifted_operandB_in;
        add_cin = flags_in[FlagC];
      end
      OpRsc: begin
        add_x   = shifted_operandB_in;
        add_y   = ~operand_a_in;
        add_cin = flags_in[FlagC];
      end
      default: ;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_cin};
  end

  always_comb begin
    case (alu_opcode_in)
      OpAnd, OpTst: dp_result = operand_a_in & shifted_operandB_in;
      OpEor, OpTeq: dp_result = operand_a_in ^ shifted_operandB_in;
      OpOrr:        dp_result = operand_a_in | shifted_operandB_in;
      OpMov:        dp_result = shifted_operandB_in;
      OpBic:        dp_result = operand_a_in & ~shifted_operandB_in;
      OpMvn:        dp_result = ~shifted_operandB_in;
      default:      dp_result = add_sum[DATA_W-1:0];
    endcase

    dp_flags        = '0;
    dp_flags[FlagN] = dp_result[DATA_W-1];
    dp_flags[FlagZ] = (dp_result == '0);
    dp_flags[FlagC] = is_arith ? add_sum[DATA_W] : carry_frm_barrel_shifter_in;
    dp_flags[FlagV] = is_arith ? ((add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                                  (add_sum[DATA_W-1] != add_x[DATA_W-1]))
                               : flags_in[FlagV];

    mul_flags        = flags_in;
    mul_flags[FlagN] = mul_product[DATA_W-1];
    mul_flags[FlagZ] = (mul_product == '0);
  end

  logic [DATA_W-1:0] result_d;
  logic [RD_W-1:0]   rd_d;
  logic [3:0]        flags_d;
  logic              wb_en_d, flags_wr_d;

  // Completion of a multiply never coincides with an accept: accept needs stall low.
  always_comb begin
    result_d   = result_out;
    rd_d       = rd_out;
    flags_d    = flags_out;
    wb_en_d    = 1'b0;
    flags_wr_d = 1'b0;
    if (mul_done) begin
      result_d   = mul_product;
      rd_d       = mul_rd;
      wb_en_d    = 1'b1;
      flags_wr_d = mul_set_flags;
      flags_d    = mul_set_flags ? mul_flags : flags_in;
    end else if (accept && instr_exec_in && !mul_in) begin
      result_d   = dp_result;
      rd_d       = rd_in;
      wb_en_d    = ~is_test;
      flags_wr_d = is_test | set_flags_in;
      flags_d    = (is_test | set_flags_in) ? dp_flags : flags_in;
    end
  end

  register_with_reset #(.Width(DATA_W)) u_result_reg (
    .clk_i(clk_in), .rst_i(reset_in), .d_i(result_d), .q_o(result_out)
  );
  register_with_reset #(.Width(RD_W)) u_rd_reg (
    .clk_i(clk_in), .rst_i(reset_in), .d_i(rd_d), .q_o(rd_out)
  );
  register_with_reset #(.Width(4)) u_flags_reg (
    .clk_i(clk_in), .rst_i(reset_in), .d_i(flags_d), .q_o(flags_out)
  );
  register_with_reset #(.Width(1)) u_wb_en_reg (
    .clk_i(clk_in), .rst_i(reset_in), .d_i(wb_en_d), .q_o(wb_en_out)
  );
  register_with_reset #(.Width(1)) u_flags_wr_reg (
    .clk_i(clk_in), .rst_i(reset_in), .d_i(flags_wr_d), .q_o(flags_wr_out)
  );

endmodule

// File: tb/tb_alu_execute_stage.sv
// Randomized self-checking bench for alu_execute_stage against an arithmetic reference model.
module tb_alu_execute_stage;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] operand_a_in = '0;
  logic [31:0] shifted_operandB_in = '0;
  logic [31:0] acc_operand_in = '0;
  logic        instr_exec_in = 1'b0;
  logic        carry_frm_barrel_shifter_in = 1'b0;
  logic [3:0]  alu_opcode_in = '0;
  logic        set_flags_in = 1'b0;
  logic        mul_in = 1'b0;
  logic        accumulate_in = 1'b0;
  logic [3:0]  rd_in = '0;
  logic [3:0]  flags_in = '0;
  logic [31:0] result_out;
  logic [3:0]  rd_out;
  logic        wb_en_out;
  logic [3:0]  flags_out;
  logic        flags_wr_out;
  logic        stall_out;

  int checks = 0;
  int errors = 0;

  alu_execute_stage #(
    .DATA_W(32),
    .RD_W  (4)
  ) dut (
    .clk_in                     (clk_in),
    .reset_in                   (reset_in),
    .valid_in                   (valid_in),
    .operand_a_in               (operand_a_in),
    .shifted_operandB_in        (shifted_operandB_in),
    .acc_operand_in             (acc_operand_in),
    .instr_exec_in              (instr_exec_in),
    .carry_frm_barrel_shifter_in(carry_frm_barrel_shifter_in),
    .alu_opcode_in              (alu_opcode_in),
    .set_flags_in               (set_flags_in),
    .mul_in                     (mul_in),
    .accumulate_in              (accumulate_in),
    .rd_in                      (rd_in),
    .flags_in                   (flags_in),
    .result_out                 (result_out),
    .rd_out                     (rd_out),
    .wb_en_out                  (wb_en_out),
    .flags_out                  (flags_out),
    .flags_wr_out               (flags_wr_out),
    .stall_out                  (stall_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic, flags as NZCV.
  function automatic void model_dp(input logic [3:0] op, input logic [31:0] a, b,
                                   input logic [3:0] fin, input logic carry, s,
                                   output logic [31:0] res, output logic [3:0] flags,
                                   output logic wb, fwr);
    longint ua, ub, sa, sb, ci, wide, sw;
    logic   arith, sub, c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'(fin[1]);
    arith = 1'b1;
    sub = 1'b0;
    wide = 0;
    sw = 0;
    res = '0;
    case (op)
      4'h0, 4'h8: begin res = a & b; arith = 1'b0; end
      4'h1, 4'h9: begin res = a ^ b; arith = 1'b0; end
      4'hC: begin res = a | b; arith = 1'b0; end
      4'hD: begin res = b; arith = 1'b0; end
      4'hE: begin res = a & ~b; arith = 1'b0; end
      4'hF: begin res = ~b; arith = 1'b0; end
      4'h4, 4'hB: begin wide = ua + ub; sw = sa + sb; end
      4'h5: begin wide = ua + ub + ci; sw = sa + sb + ci; end
      4'h2, 4'hA: begin wide = ua - ub; sw = sa - sb; sub = 1'b1; end
      4'h6: begin wide = ua - ub - (1 - ci); sw = sa - sb - (1 - ci); sub = 1'b1; end
      4'h3: begin wide = ub - ua; sw = sb - sa; sub = 1'b1; end
      default: begin wide = ub - ua - (1 - ci); sw = sb - sa - (1 - ci); sub = 1'b1; end
    endcase
    if (arith) begin
      res = wide[31:0];
      c = sub ? (wide >= 0) : (wide >= 64'sh1_0000_0000);
      v = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
    end else begin
      c = carry;
      v = fin[0];
    end
    wb  = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
    fwr = !wb || s;
    flags = fwr ? {res[31], res == 32'h0, c, v} : fin;
  endfunction

  task automatic run_dp(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                        input logic [3:0] fin, input logic carry, s, exec,
                        input logic [3:0] rd);
    logic [31:0] e_res;
    logic [3:0]  e_flags;
    logic        e_wb, e_fwr;
    model_dp(op, a, b, fin, carry, s, e_res, e_flags, e_wb, e_fwr);
    valid_in = 1'b1;
    mul_in = 1'b0;
    accumulate_in = 1'b0;
    alu_opcode_in = op;
    operand_a_in = a;
    shifted_operandB_in = b;
    flags_in = fin;
    carry_frm_barrel_shifter_in = carry;
    set_flags_in = s;
    instr_exec_in = exec;
    rd_in = rd;
    tick();
    valid_in = 1'b0;
    check_eq({tag, ".wb_en"}, 32'(wb_en_out), 32'(exec && e_wb));
    check_eq({tag, ".flags_wr"}, 32'(flags_wr_out), 32'(exec && e_fwr));
    if (exec && e_wb) begin
      check_eq({tag, ".result"}, result_out, e_res);
      check_eq({tag, ".rd"}, 32'(rd_out), 32'(rd));
    end
    if (exec) check_eq({tag, ".flags"}, 32'(flags_out), 32'(e_flags));
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] pool [5];
    pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'h7FFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 2) == 0) return pool[$urandom_range(0, 4)];
    return $urandom;
  endfunction

`ifdef ALU_EXECUTE_STAGE_MUL_EN
  task automatic run_mul(input string tag, input logic [31:0] a, rs, rn, input logic acc, s,
                         input logic [3:0] fin, rd);
    logic [31:0] e_prod;
    int          e_cycles, cnt;
    e_prod = a * rs + (acc ? rn : 32'h0);
    e_cycles = 1;
    for (int i = 0; i < 32; i++) if (rs[i]) e_cycles = i + 1;
    valid_in = 1'b1;
    mul_in = 1'b1;
    instr_exec_in = 1'b1;
    accumulate_in = acc;
    operand_a_in = a;
    shifted_operandB_in = rs;
    acc_operand_in = rn;
    set_flags_in = s;
    rd_in = rd;
    flags_in = fin;
    alu_opcode_in = 4'($urandom);
    tick();
    check_eq({tag, ".wb_at_accept"}, 32'(wb_en_out), 32'h0);
    cnt = 0;
    while (stall_out && cnt < 40) begin
      cnt++;
      valid_in = 1'($urandom);
      mul_in = 1'($urandom);
      instr_exec_in = 1'($urandom);
      accumulate_in = 1'($urandom);
      operand_a_in = $urandom;
      shifted_operandB_in = $urandom;
      acc_operand_in = $urandom;
      set_flags_in = 1'($urandom);
      rd_in = 4'($urandom);
      tick();
    end
    valid_in = 1'b0;
    check_eq({tag, ".stall_cycles"}, 32'(cnt), 32'(e_cycles));
    check_eq({tag, ".result"}, result_out, e_prod);
    check_eq({tag, ".rd"}, 32'(rd_out), 32'(rd));
    check_eq({tag, ".wb_en"}, 32'(wb_en_out), 32'h1);
    check_eq({tag, ".flags_wr"}, 32'(flags_wr_out), 32'(s));
    check_eq({tag, ".flags"}, 32'(flags_out),
             32'(s ? {e_prod[31], e_prod == 32'h0, fin[1:0]} : fin));
    tick();
    check_eq({tag, ".wb_pulse_end"}, 32'(wb_en_out), 32'h0);
  endtask
`endif

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".result"}, result_out, 32'h0);
    check_eq({tag, ".rd"}, 32'(rd_out), 32'h0);
    check_eq({tag, ".flags"}, 32'(flags_out), 32'h0);
    check_eq({tag, ".wb_en"}, 32'(wb_en_out), 32'h0);
    check_eq({tag, ".flags_wr"}, 32'(flags_wr_out), 32'h0);
    check_eq({tag, ".stall"}, 32'(stall_out), 32'h0);
  endtask

  initial begin
    #1 reset_in = 1'b1;
    #1 check_all_zero("reset_async");
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;

    run_dp("adds", 4'h4, 32'h7FFF_FFFF, 32'h1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd3);
    check_eq("adds.const_result", result_out, 32'h8000_0000);
    check_eq("adds.const_flags", 32'(flags_out), 32'b1001);
    tick();
    check_eq("adds.wb_pulse_end", 32'(wb_en_out), 32'h0);
    check_eq("adds.result_hold", result_out, 32'h8000_0000);

    run_dp("cmp", 4'hA, 32'd5, 32'd5, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd1);
    check_eq("cmp.const_flags", 32'(flags_out), 32'b0110);
    run_dp("adc", 4'h5, 32'd1, 32'd1, 4'b0010, 1'b0, 1'b0, 1'b1, 4'd2);
    check_eq("adc.const_result", result_out, 32'd3);
    run_dp("movs", 4'hD, 32'h1234, 32'h0, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd4);
    check_eq("movs.const_flags", 32'(flags_out), 32'b0111);
    run_dp("movs_noexec", 4'hD, 32'h1234, 32'h0, 4'b0001, 1'b1, 1'b1, 1'b0, 4'd4);

    for (int i = 0; i < 80; i++) begin
      run_dp($sformatf("rand_dp%0d", i), 4'($urandom), pick_operand(), pick_operand(),
             4'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0),
             4'($urandom));
    end

`ifdef ALU_EXECUTE_STAGE_MUL_EN
    run_mul("mul_3x5", 32'd3, 32'd5, 32'hDEAD, 1'b0, 1'b1, 4'b0011, 4'd7);
    run_mul("mul_rs0", 32'd9, 32'd0, 32'h0, 1'b0, 1'b1, 4'b0000, 4'd8);
    run_mul("mul_rs_msb", 32'd1, 32'h8000_0000, 32'h0, 1'b0, 1'b1, 4'b0001, 4'd9);
    run_mul("mla", 32'd2, 32'd3, 32'd10, 1'b1, 1'b0, 4'b1010, 4'd10);
    for (int i = 0; i < 10; i++) begin
      run_mul($sformatf("rand_mul%0d", i), $urandom, $urandom >> $urandom_range(0, 31),
              $urandom, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end
`else
    valid_in = 1'b1;
    mul_in = 1'b1;
    instr_exec_in = 1'b1;
    operand_a_in = 32'd3;
    shifted_operandB_in = 32'd5;
    set_flags_in = 1'b1;
    tick();
    valid_in = 1'b0;
    check_eq("nomul.stall", 32'(stall_out), 32'h0);
    check_eq("nomul.wb_en", 32'(wb_en_out), 32'h0);
    check_eq("nomul.flags_wr", 32'(flags_wr_out), 32'h0);
    tick();
    check_eq("nomul.stall_later", 32'(stall_out), 32'h0);
    run_dp("nomul_add", 4'h4, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd6);
    check_eq("nomul_add.const_result", result_out, 32'd3);
`endif

    // Mid-flight reset: outputs hold nonzero state first so the clear is observable.
    run_dp("pre_reset", 4'h4, 32'h7FFF_FFFF, 32'h1, 4'b0000, 1'b0, 1'b1, 1'b1, 4'd5);
`ifdef ALU_EXECUTE_STAGE_MUL_EN
    valid_in = 1'b1;
    mul_in = 1'b1;
    instr_exec_in = 1'b1;
    accumulate_in = 1'b0;
    operand_a_in = 32'd7;
    shifted_operandB_in = 32'h8000_0000;
    tick();
    valid_in = 1'b0;
    repeat (4) tick();
    check_eq("pre_reset.stall", 32'(stall_out), 32'h1);
`endif
    #2 reset_in = 1'b1;
    #1 check_all_zero("reset_mid");
    @(negedge clk_in);
    reset_in = 1'b0;
    run_dp("post_reset_add", 4'h4, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0, 1'b1, 4'd11);
    check_eq("post_reset_add.const_result", result_out, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_execute_stage.md
# alu_execute_stage

Execute stage of the ALU pipe, directly downstream of the barrel-shifter stage. It consumes the registered shifted operand B, instruction-execute bit and shifter carry, and performs the ARM data-processing operation and NZCV flag computation. It also runs MUL/MLA on an iterative shift-add engine that stalls the pipe. Outputs are registered results, destination register, write-back enable and the next flag value for the register file and flag register.

## Interface
- DATA_W, 32, operand/result width (fixed at 32 for ARM; parameterised for bench reuse)
- RD_W, 4, register index width

- clk_in  input  1  pipeline clock, rising edge
- reset_in  input  1  asynchronous, active-high reset
- valid_in  input  1  operands and control below are valid this cycle
- operand_a_in  input  DATA_W  Rn (DP ops) / Rm (multiply)
- shifted_operandB_in  input  DATA_W  shifted operand B (DP ops) / Rs (multiply)
- acc_operand_in  input  DATA_W  Rn accumulate operand for MLA
- instr_exec_in  input  1  condition passed
- carry_frm_barrel_shifter_in  input  1  shifter carry-out
- alu_opcode_in  input  4  ARM DP opcode (AND…MVN)
- set_flags_in  input  1  S bit
- mul_in  input  1  multiply instruction
- accumulate_in  input  1  MLA (with mul_in)
- rd_in  input  RD_W  destination register
- flags_in  input  4  current NZCV (bit3 = N … bit0 = V)
- result_out  output  DATA_W  registered result
- rd_out  output  RD_W  registered destination
- wb_en_out  output  1  result_out is to be written to rd_out (one-cycle pulse)
- flags_out  output  4  registered next NZCV
- flags_wr_out  output  1  flags_out is to be written (one-cycle pulse)
- stall_out  output  1  registered; multiply in progress, upstream holds its inputs

## Operation
- Accept: valid_in=1 and stall_out=0. Inputs are ignored while stall_out=1.
- Accept with instr_exec_in=0: wb_en_out=0 and flags_wr_out=0 next cycle. No FSM entry.
- DP ops, 1-cycle latency:
  - AND/EOR/ORR/BIC/MOV/MVN: C = carry_frm_barrel_shifter_in, V = flags_in.V.
  - ADD/ADC/SUB/SBC/RSB/RSC/CMP/CMN: 33-bit add. C = carry-out (subtract: C = NOT borrow). V = signed overflow. ADC/SBC/RSC use flags_in.C.
  - TST/TEQ/CMP/CMN: wb_en_out=0. flags_wr_out=1 always.
  - Other ops: wb_en_out=1. flags_wr_out = set_flags_in.
  - N = result[31]. Z = (result==0). flags_out = flags_in when not written.
- Multiply FSM, states IDLE and MUL:
  - IDLE→MUL on accepted mul_in with instr_exec_in=1. Load acc = accumulate_in ? acc_operand_in : 0, mcand = operand_a_in, mplier = shifted_operandB_in, plus rd and S.
  - In MUL, each cycle: if mplier[0], acc += mcand (mod 2^32). Then mcand <<= 1 and mplier >>= 1.
  - MUL→IDLE on the edge where the shifted mplier becomes 0. That edge registers result_out = acc, wb_en_out=1, and flags_wr_out = S.
  - Multiply flags: N and Z from result. C and V unchanged.
  - Cycles spent in MUL = max(1, index of highest set bit of Rs + 1), i.e. 1..32. Early termination is mandatory.
- Reset (any time, including mid-multiply): FSM→IDLE immediately. All outputs 0: result_out, rd_out, flags_out, wb_en_out, flags_wr_out, stall_out.

## Timing
- DP op accepted at edge k: outputs valid in cycle k+1 (one register stage).
- Multiply accepted at edge k:
  - stall_out=1 for cycles k+1 … k+n, where n = MUL cycles.
  - Result and wb_en_out appear in cycle k+n+1, the same cycle stall_out falls.
  - The next instruction is accepted at edge k+n+1.
- wb_en_out and flags_wr_out are single-cycle pulses. result_out, rd_out and flags_out hold between pulses.
- Flags written at edge k are not forwarded internally. The consumer sees flags_in as supplied.

## Configuration
- ALU_EXECUTE_STAGE_MUL_EN defined: multiply FSM and engine present as above.
- Undefined:
  - No multiplier logic. stall_out tied 0.
  - Accepted mul_in=1 instructions act as NOP: wb_en_out=0, flags_wr_out=0.
  - acc_operand_in and accumulate_in unused.

## Structure
- Shared define file alongside the ALU-pipe/barrel-shifter defines holds the opcode constants (AND=4'h0 … MVN=4'hF), NZCV bit positions and FSM state encodings.
- Sub-module alu_seq_multiplier holds the FSM, acc/mcand/mplier registers and the done/busy pulse. It is instantiated only under ALU_EXECUTE_STAGE_MUL_EN.
- Output registers use register_with_reset.

## Test plan
- ADDS A=0x7FFFFFFF, B=0x00000001, S=1 → result 0x80000000, flags_out=4'b1001, wb_en_out=1, cycle k+1.
- CMP A=5, B=5 → flags_out=4'b0110, flags_wr_out=1, wb_en_out=0. ADC A=1, B=1, flags_in.C=1 → result 3.
- MOVS B=0, shifter carry=1, flags_in=4'b0001 → result 0, flags_out=4'b0111. Same with instr_exec_in=0 → wb_en_out=0, flags_wr_out=0.
- MUL A=3, Rs=5 → stall 3 cycles, result 15. Rs=0 → 1 cycle, result 0. Rs=0x80000000 → 32 cycles. MLA A=2, Rs=3, Rn=10 → 16. Inputs changed during stall are ignored.
- Assert reset_in in the 5th MUL cycle → all outputs 0 asynchronously. After release, ADD A=1, B=2 is accepted and result 3 appears the next cycle.
- Build without ALU_EXECUTE_STAGE_MUL_EN: MUL A=3, Rs=5 → stall_out stays 0, wb_en_out=0, and the following ADD completes normally.
